// File: rtl/sys_pc_redirect.sv
// Fetch-side PC generator: issues sequential imem reads, tracks outstanding requests and
// handles redirects from the system and branch units by flushing and discarding stale data.
module sys_pc_redirect #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_OUT  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sys_jump_vld,
  input  logic [XLEN-1:0] i_sys_jump_pc,
  input  logic            i_br_jump_vld,
  input  logic [XLEN-1:0] i_br_jump_pc,
  input  logic            i_fetch_stall,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvld,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_fetch_vld,
  output logic [XLEN-1:0] o_fetch_pc,
  output logic [XLEN-1:0] o_fetch_instr,
  output logic            o_fetch_flush
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [3:0]      r_outCnt;
  logic            r_epoch;
  logic            r_flush;
  logic [3:0]      r_wrPtr;
  logic [3:0]      r_rdPtr;
  logic [XLEN-1:0] r_qPc    [16];
  logic            r_qEpoch [16];

  logic            w_redirect;
  logic [XLEN-1:0] w_targetRaw;
  logic [XLEN-1:0] w_target;
  logic            w_grant;
  logic            w_pop;
  logic            w_discard;
  logic [3:0]      w_nextCnt;

  assign w_redirect  = i_sys_jump_vld | i_br_jump_vld;
  assign w_targetRaw = i_sys_jump_vld ? i_sys_jump_pc : i_br_jump_pc;
  assign w_target    = {w_targetRaw[XLEN-1:2], 2'b00};

  assign o_imem_req  = (r_state == RUN) & ~i_fetch_stall & ~w_redirect & (r_outCnt < MAX_CNT);
  assign o_imem_addr = r_pc;
  assign w_grant     = o_imem_req & i_imem_gnt;

  // A response with nothing outstanding is a protocol error and is dropped without a pop.
  assign w_pop = i_imem_rvld & (r_outCnt != 4'd0);

  // Everything returning during DRAIN predates a redirect; this also covers two redirects
  // inside one drain, where the single epoch bit would have toggled back to a match.
  assign w_discard = (r_qEpoch[r_rdPtr] != r_epoch) | (r_state == DRAIN);

  assign o_fetch_vld   = w_pop & ~w_discard;
  assign o_fetch_pc    = w_pop ? r_qPc[r_rdPtr] : '0;
  assign o_fetch_instr = w_pop ? i_imem_rdata : '0;
  assign o_fetch_flush = r_flush;

  always_comb begin
    w_nextCnt = r_outCnt;
    if (w_grant && !w_pop) begin
      w_nextCnt = r_outCnt + 4'd1;
    end else if (!w_grant && w_pop) begin
      w_nextCnt = r_outCnt - 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_grant) begin
      r_qPc[r_wrPtr]    <= r_pc;
      r_qEpoch[r_wrPtr] <= r_epoch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= BOOT;
      r_pc     <= RESET_PC;
      r_outCnt <= 4'd0;
      r_epoch  <= 1'b0;
      r_flush  <= 1'b0;
      r_wrPtr  <= 4'd0;
      r_rdPtr  <= 4'd0;
    end else begin
      r_flush  <= w_redirect;
      r_outCnt <= w_nextCnt;
      if (w_grant) begin
        r_wrPtr <= r_wrPtr + 4'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 4'd1;
      end
      if (w_redirect) begin
        r_pc    <= w_target;
        r_epoch <= ~r_epoch;
      end else if (w_grant) begin
        r_pc <= r_pc + XLEN'(4);
      end
      case (r_state)
        BOOT:    r_state <= RUN;
        RUN:     if (w_redirect && (w_nextCnt != 4'd0)) r_state <= DRAIN;
        DRAIN:   if (!w_redirect && (w_nextCnt == 4'd0)) r_state <= RUN;
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule
